// File: rtl/ama_riscv_decode_queue_pkg.sv
// ama_riscv_decode_queue_pkg
// Shared types for the queued decode stage:
//   - opcode and control-select enums and the decoder_t control bundle
//   - DECODER_RST_VAL, the idle/bubble value of the control bundle
//   - dec_q_entry_t, one queued {pc, inst} pair (pc held at full 32-bit width)
//   - DEC_Q_DEPTH_DEF, the default queue depth
// Also provides DFF_RST_N, the async active-low reset flop macro that sits
// alongside the existing synchronous reset flop macros.
package ama_riscv_decode_queue_pkg;

  localparam int DEC_Q_DEPTH_DEF = 4;
  localparam int DEC_Q_PC_W_MAX  = 32;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_ARI_I    = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_ARI_R    = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    PC_SEL_INC4 = 2'd0,
    PC_SEL_ALU  = 2'd1
  } pc_sel_t;

  // Encoding is {fn7[5], fn3} so R-type ops map straight onto it
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_SRA    = 4'b1101,
    ALU_PASS_B = 4'b1111
  } alu_op_t;

  typedef enum logic {
    ALU_A_SEL_RS1 = 1'b0,
    ALU_A_SEL_PC  = 1'b1
  } alu_a_sel_t;

  typedef enum logic {
    ALU_B_SEL_RS2 = 1'b0,
    ALU_B_SEL_IMM = 1'b1
  } alu_b_sel_t;

  typedef enum logic [2:0] {
    IG_DISABLED = 3'd0,
    IG_I_TYPE   = 3'd1,
    IG_S_TYPE   = 3'd2,
    IG_B_TYPE   = 3'd3,
    IG_J_TYPE   = 3'd4,
    IG_U_TYPE   = 3'd5
  } ig_sel_t;

  typedef enum logic [1:0] {
    WB_SEL_DMEM = 2'd0,
    WB_SEL_ALU  = 2'd1,
    WB_SEL_INC4 = 2'd2,
    WB_SEL_CSR  = 2'd3
  } wb_sel_t;

  typedef struct packed {
    logic en;
    logic we;
    logic re;
    logic ui;
  } csr_ctrl_t;

  typedef struct packed {
    pc_sel_t    pc_sel;
    logic       pc_we;
    logic       load_inst;
    logic       store_inst;
    logic       branch_inst;
    logic       jump_inst;
    alu_op_t    alu_op;
    alu_a_sel_t alu_a_sel;
    alu_b_sel_t alu_b_sel;
    ig_sel_t    ig_sel;
    logic       bc_uns;
    logic       dmem_en;
    logic       load_sm_en;
    wb_sel_t    wb_sel;
    csr_ctrl_t  csr_ctrl;
    logic       rd_we;
  } decoder_t;

  localparam decoder_t DECODER_RST_VAL = '{
    pc_sel:      PC_SEL_INC4,
    pc_we:       1'b0,
    load_inst:   1'b0,
    store_inst:  1'b0,
    branch_inst: 1'b0,
    jump_inst:   1'b0,
    alu_op:      ALU_ADD,
    alu_a_sel:   ALU_A_SEL_RS1,
    alu_b_sel:   ALU_B_SEL_RS2,
    ig_sel:      IG_DISABLED,
    bc_uns:      1'b0,
    dmem_en:     1'b0,
    load_sm_en:  1'b0,
    wb_sel:      WB_SEL_DMEM,
    csr_ctrl:    '{en: 1'b0, we: 1'b0, re: 1'b0, ui: 1'b0},
    rd_we:       1'b0
  };

  typedef struct packed {
    logic [DEC_Q_PC_W_MAX-1:0] pc;
    logic [31:0]               inst;
  } dec_q_entry_t;

endpackage

`ifndef DFF_RST_N
`define DFF_RST_N(clk, rst_n, q, d, rst_val) \
  always_ff @(posedge clk or negedge rst_n) begin \
    if (!rst_n) q <= (rst_val); \
    else q <= (d); \
  end
`endif

// File: rtl/ama_riscv_decode_queue_if.sv
// ama_riscv_decode_queue_if
// Fetch-side and execute-side handshakes of the queued decode stage.
//   in_valid/in_ready/in_pc/in_inst                  : fetch pushes {pc, inst}
//   out_valid/out_ready/out_decoded/out_pc/out_inst/
//   out_illegal                                      : decoded instruction to execute
// master = surrounding pipeline (fetch + execute), slave = decode queue.
interface ama_riscv_decode_queue_if #(
  parameter int PC_W = 32
) ();
  import ama_riscv_decode_queue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_inst;

  logic            out_valid;
  logic            out_ready;
  decoder_t        out_decoded;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_decoded, out_pc, out_inst, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_decoded, out_pc, out_inst, out_illegal
  );
endinterface

// File: rtl/ama_riscv_decode_core.sv
// ama_riscv_decode_core
// Purely combinational RV32I decoder: instruction word -> control bundle.
//   inst_i    : 32-bit instruction word
//   decoded_o : decoder_t control bundle (DECODER_RST_VAL for unknown opcodes)
//   illegal_o : instruction is illegal
// Build option AMA_RISCV_DEC_ILLEGAL_CHK_EN enables illegal-instruction
// detection; an illegal instruction is turned into a harmless pc+4 bubble.
// Without it illegal_o is tied low and nothing is forced.
module ama_riscv_decode_core
  import ama_riscv_decode_queue_pkg::*;
(
  input  logic [31:0] inst_i,
  output decoder_t    decoded_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;
  logic [4:0] rs1;
  logic       rdNz;
  logic       unusedInstBits;
  decoder_t   dec;

  assign opcode = inst_i[6:0];
  assign fn3    = inst_i[14:12];
  assign fn7    = inst_i[31:25];
  assign rs1    = inst_i[19:15];
  assign rdNz   = (inst_i[11:7] != 5'd0);

  // Not every instruction bit steers control (rs2, immediates)
  assign unusedInstBits = ^inst_i;

  // Per-opcode control; fields an opcode does not care about stay at reset value
  always_comb begin
    dec = DECODER_RST_VAL;
    case (opcode)
      OPC_ARI_R: begin
        dec.pc_we  = 1'b1;
        dec.alu_op = alu_op_t'({fn7[5], fn3});
        dec.wb_sel = WB_SEL_ALU;
        dec.rd_we  = rdNz;
      end
      OPC_ARI_I: begin
        // only SRAI carries fn7[5]; in other I-types that bit is immediate
        dec.pc_we     = 1'b1;
        dec.alu_op    = alu_op_t'({(fn3 == 3'b101) && fn7[5], fn3});
        dec.alu_b_sel = ALU_B_SEL_IMM;
        dec.ig_sel    = IG_I_TYPE;
        dec.wb_sel    = WB_SEL_ALU;
        dec.rd_we     = rdNz;
      end
      OPC_LOAD: begin
        dec.pc_we      = 1'b1;
        dec.load_inst  = 1'b1;
        dec.alu_b_sel  = ALU_B_SEL_IMM;
        dec.ig_sel     = IG_I_TYPE;
        dec.dmem_en    = 1'b1;
        dec.load_sm_en = 1'b1;
        dec.wb_sel     = WB_SEL_DMEM;
        dec.rd_we      = rdNz;
      end
      OPC_STORE: begin
        dec.pc_we      = 1'b1;
        dec.store_inst = 1'b1;
        dec.alu_b_sel  = ALU_B_SEL_IMM;
        dec.ig_sel     = IG_S_TYPE;
        dec.dmem_en    = 1'b1;
      end
      OPC_BRANCH: begin
        dec.pc_we       = 1'b1;
        dec.branch_inst = 1'b1;
        dec.alu_a_sel   = ALU_A_SEL_PC;
        dec.alu_b_sel   = ALU_B_SEL_IMM;
        dec.ig_sel      = IG_B_TYPE;
        dec.bc_uns      = fn3[1];
      end
      OPC_JAL: begin
        dec.pc_sel    = PC_SEL_ALU;
        dec.pc_we     = 1'b1;
        dec.jump_inst = 1'b1;
        dec.alu_a_sel = ALU_A_SEL_PC;
        dec.alu_b_sel = ALU_B_SEL_IMM;
        dec.ig_sel    = IG_J_TYPE;
        dec.wb_sel    = WB_SEL_INC4;
        dec.rd_we     = rdNz;
      end
      OPC_JALR: begin
        dec.pc_sel    = PC_SEL_ALU;
        dec.pc_we     = 1'b1;
        dec.jump_inst = 1'b1;
        dec.alu_b_sel = ALU_B_SEL_IMM;
        dec.ig_sel    = IG_I_TYPE;
        dec.wb_sel    = WB_SEL_INC4;
        dec.rd_we     = rdNz;
      end
      OPC_LUI: begin
        dec.pc_we     = 1'b1;
        dec.alu_op    = ALU_PASS_B;
        dec.alu_b_sel = ALU_B_SEL_IMM;
        dec.ig_sel    = IG_U_TYPE;
        dec.wb_sel    = WB_SEL_ALU;
        dec.rd_we     = rdNz;
      end
      OPC_AUIPC: begin
        dec.pc_we     = 1'b1;
        dec.alu_a_sel = ALU_A_SEL_PC;
        dec.alu_b_sel = ALU_B_SEL_IMM;
        dec.ig_sel    = IG_U_TYPE;
        dec.wb_sel    = WB_SEL_ALU;
        dec.rd_we     = rdNz;
      end
      OPC_SYSTEM: begin
        // CSRRS/C with rs1 = x0 must not write; CSRRW with rd = x0 must not read
        dec.pc_we       = 1'b1;
        dec.csr_ctrl.en = 1'b1;
        dec.csr_ctrl.we = (fn3[1:0] == 2'b01) || (rs1 != 5'd0);
        dec.csr_ctrl.re = (fn3[1:0] != 2'b01) || rdNz;
        dec.csr_ctrl.ui = fn3[2];
        dec.wb_sel      = WB_SEL_CSR;
        dec.rd_we       = rdNz;
      end
      OPC_MISC_MEM: begin
        dec.pc_we = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef AMA_RISCV_DEC_ILLEGAL_CHK_EN
  logic illegal;

  // Illegal encodings become a side-effect-free pc+4 bubble
  always_comb begin
    illegal = (inst_i[1:0] != 2'b11);
    case (opcode)
      OPC_LOAD:   if ((fn3 == 3'd3) || (fn3 == 3'd6) || (fn3 == 3'd7)) illegal = 1'b1;
      OPC_STORE:  if (fn3 >= 3'd3) illegal = 1'b1;
      OPC_BRANCH: if ((fn3 == 3'd2) || (fn3 == 3'd3)) illegal = 1'b1;
      OPC_JALR:   if (fn3 != 3'd0) illegal = 1'b1;
      OPC_ARI_R: begin
        if ((fn7 != 7'h00) && (fn7 != 7'h20)) illegal = 1'b1;
        if ((fn7 == 7'h20) && (fn3 != 3'd0) && (fn3 != 3'd5)) illegal = 1'b1;
      end
      OPC_SYSTEM: if (fn3 == 3'd4) illegal = 1'b1;
      OPC_ARI_I, OPC_AUIPC, OPC_LUI, OPC_JAL, OPC_MISC_MEM: ;
      default: illegal = 1'b1;
    endcase

    decoded_o = dec;
    if (illegal) begin
      decoded_o.rd_we       = 1'b0;
      decoded_o.dmem_en     = 1'b0;
      decoded_o.csr_ctrl.we = 1'b0;
      decoded_o.pc_sel      = PC_SEL_INC4;
      decoded_o.pc_we       = 1'b1;
    end
  end

  assign illegal_o = illegal;
`else
  assign decoded_o = dec;
  assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/ama_riscv_decode_queue.sv
// ama_riscv_decode_queue
// Decode stage with a DEPTH-entry instruction queue in front of a registered
// decode output, valid/ready on both sides.
//   clk, rst_n : clock, async active-low reset
//   flush_i    : synchronous discard of everything queued and presented
//   bus_if     : slave side of ama_riscv_decode_queue_if (fetch in, execute out)
//   level_o    : queue occupancy, not counting the output register
// Illegal-instruction detection is enabled by AMA_RISCV_DEC_ILLEGAL_CHK_EN
// (handled inside ama_riscv_decode_core).
module ama_riscv_decode_queue
  import ama_riscv_decode_queue_pkg::*;
#(
  parameter int DEPTH = DEC_Q_DEPTH_DEF,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  ama_riscv_decode_queue_if.slave    bus_if,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  dec_q_entry_t     queueMem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             inReady_q, inReady_d;
  logic             outValid_q, outValid_d;
  logic             outIllegal_q, outIllegal_d;
  decoder_t         outDecoded_q, outDecoded_d;
  logic [PC_W-1:0]  outPc_q, outPc_d;
  logic [31:0]      outInst_q, outInst_d;

  logic             push;
  logic             load;
  logic             takeHead;
  logic             takeBypass;
  logic             writeTail;
  dec_q_entry_t     inEntry;
  dec_q_entry_t     selEntry;
  decoder_t         coreDecoded;
  logic             coreIllegal;

  // The output register refills whenever it is empty or being consumed. The
  // queue head has precedence; an empty queue lets a fresh push skip straight
  // through, so it never occupies an entry.
  assign push       = bus_if.in_valid && inReady_q;
  assign load       = !outValid_q || bus_if.out_ready;
  assign takeHead   = load && (level_q != '0);
  assign takeBypass = load && (level_q == '0) && push;
  assign writeTail  = push && !takeBypass;

  assign inEntry  = '{pc: DEC_Q_PC_W_MAX'(bus_if.in_pc), inst: bus_if.in_inst};
  assign selEntry = takeHead ? queueMem_q[rdPtr_q] : inEntry;

  ama_riscv_decode_core u_core (
    .inst_i    (selEntry.inst),
    .decoded_o (coreDecoded),
    .illegal_o (coreIllegal)
  );

  // Next state: flush wins over any push/pop in the same cycle
  always_comb begin
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    level_d      = level_q;
    outValid_d   = outValid_q;
    outDecoded_d = outDecoded_q;
    outIllegal_d = outIllegal_q;
    outPc_d      = outPc_q;
    outInst_d    = outInst_q;

    if (flush_i) begin
      wrPtr_d      = '0;
      rdPtr_d      = '0;
      level_d      = '0;
      outValid_d   = 1'b0;
      outDecoded_d = DECODER_RST_VAL;
      outIllegal_d = 1'b0;
    end else begin
      if (writeTail) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (takeHead)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({writeTail, takeHead})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: ;
      endcase
      if (load) begin
        outValid_d = takeHead || takeBypass;
        if (takeHead || takeBypass) begin
          outDecoded_d = coreDecoded;
          outIllegal_d = coreIllegal;
          outPc_d      = PC_W'(selEntry.pc);
          outInst_d    = selEntry.inst;
        end
      end
    end

    // registered ready: known one cycle ahead, independent of out_ready
    inReady_d = (level_d != LVL_W'(DEPTH));
  end

  // Queue storage has no reset; stale entries are never read
  always_ff @(posedge clk) begin
    if (writeTail && !flush_i) queueMem_q[wrPtr_q] <= inEntry;
  end

  // Control and output registers
  `DFF_RST_N(clk, rst_n, wrPtr_q, wrPtr_d, '0)
  `DFF_RST_N(clk, rst_n, rdPtr_q, rdPtr_d, '0)
  `DFF_RST_N(clk, rst_n, level_q, level_d, '0)
  `DFF_RST_N(clk, rst_n, inReady_q, inReady_d, 1'b1)
  `DFF_RST_N(clk, rst_n, outValid_q, outValid_d, 1'b0)
  `DFF_RST_N(clk, rst_n, outDecoded_q, outDecoded_d, DECODER_RST_VAL)
  `DFF_RST_N(clk, rst_n, outIllegal_q, outIllegal_d, 1'b0)
  `DFF_RST_N(clk, rst_n, outPc_q, outPc_d, '0)
  `DFF_RST_N(clk, rst_n, outInst_q, outInst_d, '0)

  assign bus_if.in_ready    = inReady_q;
  assign bus_if.out_valid   = outValid_q;
  assign bus_if.out_decoded = outDecoded_q;
  assign bus_if.out_pc      = outPc_q;
  assign bus_if.out_inst    = outInst_q;
  assign bus_if.out_illegal = outIllegal_q;
  assign level_o            = level_q;

endmodule

// File: tb/tb_ama_riscv_decode_queue.sv
// tb_ama_riscv_decode_queue
// Directed checks of the queued decode stage (reset, latency, backpressure,
// ordering, flush, illegal handling, async reset) plus a short random phase
// compared against a small queue model.
module tb_ama_riscv_decode_queue;
  import ama_riscv_decode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [$clog2(DEPTH+1)-1:0] level;

  int assertCount = 0;
  int failCount   = 0;

  decoder_t expAddi, expAdd, expLw;
  logic [31:0] modelQ[$];
  logic        mValid, mReady, rv, rr;
  int          mLevel;
  logic [31:0] rInst;

  ama_riscv_decode_queue_if #(.PC_W(PC_W)) bus ();

  ama_riscv_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus_if  (bus),
    .level_o (level)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, return at the falling edge
  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                               input logic ready, input logic fl);
    bus.in_valid  = valid;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = ready;
    flush         = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mkAddi(input int i);
    return {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13};
  endfunction

  initial begin
    expAddi = DECODER_RST_VAL;
    expAddi.pc_we = 1'b1; expAddi.alu_b_sel = ALU_B_SEL_IMM; expAddi.ig_sel = IG_I_TYPE;
    expAddi.wb_sel = WB_SEL_ALU; expAddi.rd_we = 1'b1;
    expAdd = DECODER_RST_VAL;
    expAdd.pc_we = 1'b1; expAdd.wb_sel = WB_SEL_ALU; expAdd.rd_we = 1'b1;
    expLw = DECODER_RST_VAL;
    expLw.pc_we = 1'b1; expLw.load_inst = 1'b1; expLw.alu_b_sel = ALU_B_SEL_IMM;
    expLw.ig_sel = IG_I_TYPE; expLw.dmem_en = 1'b1; expLw.load_sm_en = 1'b1;
    expLw.wb_sel = WB_SEL_DMEM; expLw.rd_we = 1'b1;

    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b0;
    flush = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_decoded", bus.out_decoded, DECODER_RST_VAL);
    checkOutput("rst_pc", bus.out_pc, 0);
    checkOutput("rst_inst", bus.out_inst, 0);
    checkOutput("rst_illegal", bus.out_illegal, 0);
    rst_n = 1'b1;

    // single addi, one-cycle latency through the bypass
    applyStimulus(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0);
    checkOutput("addi_valid", bus.out_valid, 1);
    checkOutput("addi_decoded", bus.out_decoded, expAddi);
    checkOutput("addi_b_sel", bus.out_decoded.alu_b_sel, ALU_B_SEL_IMM);
    checkOutput("addi_ig_sel", bus.out_decoded.ig_sel, IG_I_TYPE);
    checkOutput("addi_rd_we", bus.out_decoded.rd_we, 1);
    checkOutput("addi_level", level, 0);
    checkOutput("addi_pc", bus.out_pc, 32'h100);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("addi_drained", bus.out_valid, 0);

    // backpressure: 6 offered, 5 accepted (1 in output register + 4 queued)
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("bp_in_ready_%0d", i), bus.in_ready, (i < 5) ? 1 : 0);
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), mkAddi(i), 1'b0, 1'b0);
    end
    checkOutput("bp_level_full", level, 4);
    checkOutput("bp_in_ready_full", bus.in_ready, 0);
    checkOutput("bp_hold_pc", bus.out_pc, 32'h200);
    checkOutput("bp_hold_inst", bus.out_inst, mkAddi(0));
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (k < 5) begin
        checkOutput($sformatf("drain_valid_%0d", k), bus.out_valid, 1);
        checkOutput($sformatf("drain_pc_%0d", k), bus.out_pc, 32'h200 + 32'(4 * k));
        checkOutput($sformatf("drain_inst_%0d", k), bus.out_inst, mkAddi(k));
        checkOutput($sformatf("drain_level_%0d", k), level, 4 - k);
      end else begin
        checkOutput("drain_empty_valid", bus.out_valid, 0);
        checkOutput("drain_empty_level", level, 0);
      end
    end

    // add then lw back to back
    applyStimulus(1'b1, 32'h300, 32'h002081B3, 1'b1, 1'b0);
    checkOutput("add_decoded", bus.out_decoded, expAdd);
    checkOutput("add_wb_sel", bus.out_decoded.wb_sel, WB_SEL_ALU);
    checkOutput("add_load", bus.out_decoded.load_inst, 0);
    applyStimulus(1'b1, 32'h304, 32'h0000A283, 1'b1, 1'b0);
    checkOutput("lw_valid", bus.out_valid, 1);
    checkOutput("lw_pc", bus.out_pc, 32'h304);
    checkOutput("lw_decoded", bus.out_decoded, expLw);
    checkOutput("lw_wb_sel", bus.out_decoded.wb_sel, WB_SEL_DMEM);
    checkOutput("lw_load", bus.out_decoded.load_inst, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // flush with level 3 and a simultaneous push
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h400 + 32'(4 * i), mkAddi(i + 8), 1'b0, 1'b0);
    checkOutput("fl_level_pre", level, 3);
    applyStimulus(1'b1, 32'h4F0, 32'h00700393, 1'b0, 1'b1);
    checkOutput("fl_level", level, 0);
    checkOutput("fl_valid", bus.out_valid, 0);
    checkOutput("fl_decoded", bus.out_decoded, DECODER_RST_VAL);
    checkOutput("fl_illegal", bus.out_illegal, 0);
    checkOutput("fl_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("fl_stays_empty_%0d", i), bus.out_valid, 0);
    end

    // all-ones word and a store (rd field must not enable writeback)
    applyStimulus(1'b1, 32'h500, 32'hFFFFFFFF, 1'b1, 1'b0);
`ifdef AMA_RISCV_DEC_ILLEGAL_CHK_EN
    checkOutput("ill_flag", bus.out_illegal, 1);
    checkOutput("ill_rd_we", bus.out_decoded.rd_we, 0);
    checkOutput("ill_dmem_en", bus.out_decoded.dmem_en, 0);
    checkOutput("ill_pc_we", bus.out_decoded.pc_we, 1);
`else
    checkOutput("ill_flag", bus.out_illegal, 0);
    checkOutput("ill_decoded", bus.out_decoded, DECODER_RST_VAL);
`endif
    applyStimulus(1'b1, 32'h504, 32'h0020A223, 1'b1, 1'b0);
    checkOutput("sw_store", bus.out_decoded.store_inst, 1);
    checkOutput("sw_rd_we", bus.out_decoded.rd_we, 0);
    checkOutput("sw_dmem_en", bus.out_decoded.dmem_en, 1);
    checkOutput("sw_ig_sel", bus.out_decoded.ig_sel, IG_S_TYPE);
    checkOutput("sw_illegal", bus.out_illegal, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // asynchronous reset in the middle of a cycle
    applyStimulus(1'b1, 32'h600, mkAddi(20), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h604, mkAddi(21), 1'b0, 1'b0);
    checkOutput("mid_level_pre", level, 1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", bus.out_valid, 0);
    checkOutput("mid_rst_level", level, 0);
    checkOutput("mid_rst_pc", bus.out_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // random push/pop against a queue model (output register = model head)
    for (int c = 0; c < 40; c++) begin
      mValid = (modelQ.size() > 0);
      mLevel = mValid ? modelQ.size() - 1 : 0;
      mReady = (mLevel != DEPTH);
      checkOutput($sformatf("rnd_valid_%0d", c), bus.out_valid, mValid);
      checkOutput($sformatf("rnd_level_%0d", c), level, mLevel);
      checkOutput($sformatf("rnd_in_ready_%0d", c), bus.in_ready, mReady);
      if (mValid) checkOutput($sformatf("rnd_inst_%0d", c), bus.out_inst, modelQ[0]);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 1) != 0);
      rInst = $urandom();
      rInst[6:0] = 7'h13;
      applyStimulus(rv, 32'h1000 + 32'(4 * c), rInst, rr, 1'b0);
      if (mValid && rr) void'(modelQ.pop_front());
      if (rv && mReady) modelQ.push_back(rInst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
